// File: rtl/shutter_monitor.sv
// -----------------------------------------------------------------------------
// shutter_monitor
//
// Receive-side checker for the camera shutter line. The line is sampled every
// clock and decoded against the two-pulse exposure pattern:
//
//   pulse (PULSE_W highs) -> gap (GAP_LEN lows) -> pulse (PULSE_W highs)
//   -> quiet (MIN_QUIET lows, the low that ends the 2nd pulse counts as the
//      first of them) -> ready for the next frame
//
// Every decision taken on the sample at edge N is visible right after edge N
// (one cycle of latency from the sampled shutter cycle). All outputs are
// registered.
//
// After any protocol violation the monitor sits in RECOVER until it has seen
// MIN_QUIET consecutive lows; nothing is reported while recovering, so one
// mangled frame produces exactly one error strobe.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   shutter    shutter line from the sequencer (already synchronous)
//   clr_cnt    synchronous clear of frame_cnt and err_cnt (wins over an
//              increment on the same edge)
//   frame_ok   one-cycle pulse: a complete, legal frame was decoded
//   frame_err  one-cycle pulse: a protocol violation was detected
//   err_code   code of the most recent error, held until the next one:
//              00 QUIET, 01 WIDTH, 10 GAP_SHORT, 11 GAP_TIMEOUT
//   frame_cnt  good-frame count, wraps
//   err_cnt    error count, saturates at all-ones
//   busy       high whenever the decoder is not idle
// -----------------------------------------------------------------------------
module shutter_monitor #(
  parameter int PULSE_W   = 1,   // 1..15
  parameter int GAP_LEN   = 2,   // 1..15
  parameter int MIN_QUIET = 6,   // 2..15
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shutter,
  input  logic             clr_cnt,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  // Decoder phases. Encodings 6 and 7 are unused; landing in one of them
  // (e.g. after an upset) parks the decoder in RECOVER without an error.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_P1      = 3'd1,
    S_GAP     = 3'd2,
    S_P2      = 3'd3,
    S_QUIET   = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    E_QUIET       = 2'b00,
    E_WIDTH       = 2'b01,
    E_GAP_SHORT   = 2'b10,
    E_GAP_TIMEOUT = 2'b11
  } err_t;

  // Parameter values narrowed to the width of the phase counter.
  localparam logic [3:0] PW = 4'(PULSE_W);
  localparam logic [3:0] GL = 4'(GAP_LEN);
  localparam logic [3:0] MQ = 4'(MIN_QUIET);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     state_n;
  logic [3:0] c;        // cycles spent in the current phase
  logic [3:0] c_n;
  logic [3:0] c_inc;
  logic       ok_n;
  logic       err_n;
  err_t       code_n;

  assign c_inc = c + 4'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      c     <= 4'd0;
    end else begin
      state <= state_n;
      c     <= c_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / decision logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    c_n     = c;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    code_n  = E_QUIET;

    case (state)
      S_IDLE: begin
        if (shutter) begin
          c_n     = 4'd1;
          state_n = S_P1;
        end else begin
          c_n = 4'd0;
        end
      end

      S_P1: begin
        if (shutter) begin
          if (c == PW) begin
            err_n   = 1'b1;
            code_n  = E_WIDTH;
            c_n     = 4'd0;
            state_n = S_RECOVER;
          end else begin
            c_n = c_inc;
          end
        end else begin
          // This low is the first gap cycle.
          c_n     = 4'd1;
          state_n = S_GAP;
        end
      end

      S_GAP: begin
        if (!shutter) begin
          if (c == GL) begin
            // The timed-out low already counts toward recovery.
            err_n   = 1'b1;
            code_n  = E_GAP_TIMEOUT;
            c_n     = 4'd1;
            state_n = S_RECOVER;
          end else begin
            c_n = c_inc;
          end
        end else if (c == GL) begin
          c_n     = 4'd1;
          state_n = S_P2;
        end else begin
          err_n   = 1'b1;
          code_n  = E_GAP_SHORT;
          c_n     = 4'd0;
          state_n = S_RECOVER;
        end
      end

      S_P2: begin
        if (shutter) begin
          if (c == PW) begin
            err_n   = 1'b1;
            code_n  = E_WIDTH;
            c_n     = 4'd0;
            state_n = S_RECOVER;
          end else begin
            c_n = c_inc;
          end
        end else begin
          // Falling edge of the second pulse completes the frame; this low
          // is quiet cycle 1.
          ok_n    = 1'b1;
          c_n     = 4'd1;
          state_n = S_QUIET;
        end
      end

      S_QUIET: begin
        if (shutter) begin
          err_n   = 1'b1;
          code_n  = E_QUIET;
          c_n     = 4'd0;
          state_n = S_RECOVER;
        end else if (c_inc == MQ) begin
          c_n     = 4'd0;
          state_n = S_IDLE;
        end else begin
          c_n = c_inc;
        end
      end

      S_RECOVER: begin
        // Any high restarts the quiet count; no errors are raised here.
        if (shutter) begin
          c_n = 4'd0;
        end else if (c_inc == MQ) begin
          c_n     = 4'd0;
          state_n = S_IDLE;
        end else begin
          c_n = c_inc;
        end
      end

      default: begin
        c_n     = 4'd0;
        state_n = S_RECOVER;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= E_QUIET;
      busy      <= 1'b0;
    end else begin
      frame_ok  <= ok_n;
      frame_err <= err_n;
      busy      <= (state_n != S_IDLE);
      if (err_n) begin
        err_code <= code_n;
      end
    end
  end

  // A clear on the same edge as an increment leaves the counter at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (clr_cnt) begin
      frame_cnt <= '0;
    end else if (ok_n) begin
      frame_cnt <= frame_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (err_n && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_shutter_monitor.sv
// -----------------------------------------------------------------------------
// tb_shutter_monitor
//
// Bench for shutter_monitor with default parameters. A behavioural model
// tracks run lengths of highs and lows and the position in the exposure
// pattern; at each rising edge it pushes the expected output word into
// exp_q, and a compare process pops and checks it on the following falling
// edge. Directed sequences add hand-computed literal checks, then a
// randomized phase mixes legal, perturbed and noise frames with sporadic
// counter clears.
// -----------------------------------------------------------------------------
module tb_shutter_monitor;

  localparam int PULSE_W   = 1;
  localparam int GAP_LEN   = 2;
  localparam int MIN_QUIET = 6;
  localparam int CNT_W     = 8;
  localparam int EXP_W     = 5 + 2 * CNT_W;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             shutter = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             frame_ok;
  logic             frame_err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             busy;

  always #5 clk = ~clk;

  shutter_monitor #(
    .PULSE_W  (PULSE_W),
    .GAP_LEN  (GAP_LEN),
    .MIN_QUIET(MIN_QUIET),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .shutter  (shutter),
    .clr_cnt  (clr_cnt),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: pattern position + run lengths of the shutter line
  // ---------------------------------------------------------------------------
  localparam int M_IDLE  = 0;  // waiting for a first pulse
  localparam int M_P1    = 1;  // inside first pulse
  localparam int M_GAP   = 2;  // inside the low gap
  localparam int M_P2    = 3;  // inside second pulse
  localparam int M_QUIET = 4;  // lows after a good frame
  localparam int M_REC   = 5;  // waiting out a violation

  logic [EXP_W-1:0] exp_q[$];

  int               mode;
  int               hi_run;
  int               lo_run;
  int               prev_lo;
  int               rec_lows;
  logic             m_ok;
  logic             m_err;
  logic             m_busy;
  logic [1:0]       m_code;
  logic [CNT_W-1:0] m_fcnt;
  logic [CNT_W-1:0] m_ecnt;

  task model_err(input logic [1:0] code, input int start_lows);
    m_err    = 1'b1;
    m_code   = code;
    if (m_ecnt != '1) m_ecnt = m_ecnt + 1'b1;
    mode     = M_REC;
    rec_lows = start_lows;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mode     = M_IDLE;
      hi_run   = 0;
      lo_run   = 0;
      rec_lows = 0;
      m_ok     = 1'b0;
      m_err    = 1'b0;
      m_busy   = 1'b0;
      m_code   = 2'b00;
      m_fcnt   = '0;
      m_ecnt   = '0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      m_ok    = 1'b0;
      m_err   = 1'b0;
      prev_lo = lo_run;
      if (shutter) begin
        hi_run++;
        lo_run = 0;
      end else begin
        lo_run++;
        hi_run = 0;
      end
      case (mode)
        M_IDLE: if (shutter) mode = M_P1;
        M_P1: begin
          if (shutter) begin
            if (hi_run > PULSE_W) model_err(2'b01, 0);
          end else begin
            mode = M_GAP;
          end
        end
        M_GAP: begin
          if (!shutter) begin
            if (lo_run > GAP_LEN) model_err(2'b11, 1);
          end else if (prev_lo == GAP_LEN) begin
            mode = M_P2;
          end else begin
            model_err(2'b10, 0);
          end
        end
        M_P2: begin
          if (shutter) begin
            if (hi_run > PULSE_W) model_err(2'b01, 0);
          end else begin
            m_ok   = 1'b1;
            m_fcnt = m_fcnt + 1'b1;
            mode   = M_QUIET;
          end
        end
        M_QUIET: begin
          if (shutter) model_err(2'b00, 0);
          else if (lo_run >= MIN_QUIET) mode = M_IDLE;
        end
        default: begin
          if (shutter) rec_lows = 0;
          else rec_lows++;
          if (rec_lows >= MIN_QUIET) mode = M_IDLE;
        end
      endcase
      if (clr_cnt) begin
        m_fcnt = '0;
        m_ecnt = '0;
      end
      m_busy = (mode != M_IDLE);
      exp_q.push_back({m_ok, m_err, m_code, m_busy, m_fcnt, m_ecnt});
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard compare
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0] e;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("frame_ok",  int'(frame_ok),  int'(e[EXP_W-1]));
      chk("frame_err", int'(frame_err), int'(e[EXP_W-2]));
      chk("err_code",  int'(err_code),  int'(e[EXP_W-3 -: 2]));
      chk("busy",      int'(busy),      int'(e[2*CNT_W]));
      chk("frame_cnt", int'(frame_cnt), int'(e[2*CNT_W-1 -: CNT_W]));
      chk("err_cnt",   int'(err_cnt),   int'(e[CNT_W-1:0]));
      chk("strobe_excl", int'(frame_ok & frame_err), 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  logic rand_clr_en = 1'b0;

  // Apply one sample; returns just after the edge that consumes it.
  task step(input logic sh, input logic clr);
    @(negedge clk);
    shutter = sh;
    clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_clr();
    return rand_clr_en && ($urandom_range(0, 40) == 0);
  endfunction

  task frame_custom(input int p1, input int gap, input int p2, input int quiet);
    repeat (p1)    step(1'b1, pick_clr());
    repeat (gap)   step(1'b0, pick_clr());
    repeat (p2)    step(1'b1, pick_clr());
    repeat (quiet) step(1'b0, pick_clr());
  endtask

  task legal_frame();
    frame_custom(PULSE_W, GAP_LEN, PULSE_W, MIN_QUIET);
  endtask

  task check_all_zero(input string tag);
    chk({tag, "_ok"},   int'(frame_ok),  0);
    chk({tag, "_err"},  int'(frame_err), 0);
    chk({tag, "_code"}, int'(err_code),  0);
    chk({tag, "_fcnt"}, int'(frame_cnt), 0);
    chk({tag, "_ecnt"}, int'(err_cnt),   0);
    chk({tag, "_busy"}, int'(busy),      0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int r;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset");

    // Legal frame: 1,0,0,1,0 then zeros.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("legal_ok_early", int'(frame_ok), 0);
    step(1'b0, 1'b0);                          // quiet low 1
    chk("legal_ok", int'(frame_ok), 1);
    chk("legal_fcnt", int'(frame_cnt), 1);
    step(1'b0, 1'b0);                          // quiet low 2
    chk("legal_ok_once", int'(frame_ok), 0);
    repeat (3) step(1'b0, 1'b0);               // quiet lows 3..5
    chk("legal_busy_q5", int'(busy), 1);
    step(1'b0, 1'b0);                          // quiet low 6
    chk("legal_busy_q6", int'(busy), 0);
    repeat (2) step(1'b0, 1'b0);
    chk("legal_ecnt", int'(err_cnt), 0);

    // Wide pulse.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("wide_err", int'(frame_err), 1);
    chk("wide_code", int'(err_code), 1);
    repeat (5) step(1'b0, 1'b0);
    chk("wide_busy_5", int'(busy), 1);
    step(1'b0, 1'b0);
    chk("wide_busy_6", int'(busy), 0);
    legal_frame();
    chk("wide_then_fcnt", int'(frame_cnt), 1);

    // Short gap, then gap timeout.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("short_err", int'(frame_err), 1);
    chk("short_code", int'(err_code), 2);
    repeat (6) step(1'b0, 1'b0);
    chk("short_idle", int'(busy), 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("tmo_err", int'(frame_err), 1);
    chk("tmo_code", int'(err_code), 3);
    chk("tmo_ecnt", int'(err_cnt), 2);
    repeat (4) step(1'b0, 1'b0);
    chk("tmo_busy_4", int'(busy), 1);
    step(1'b0, 1'b0);
    chk("tmo_busy_5", int'(busy), 0);

    // Quiet violation on quiet cycle 3.
    step(1'b0, 1'b1);
    frame_custom(PULSE_W, GAP_LEN, PULSE_W, 2);
    step(1'b1, 1'b0);
    chk("quiet_err", int'(frame_err), 1);
    chk("quiet_code", int'(err_code), 0);
    chk("quiet_fcnt", int'(frame_cnt), 1);
    chk("quiet_ecnt", int'(err_cnt), 1);
    step(1'b0, 1'b0);
    chk("quiet_no_frame", int'(frame_ok), 0);
    repeat (5) step(1'b0, 1'b0);
    chk("quiet_recovered", int'(busy), 0);
    chk("quiet_fcnt_after", int'(frame_cnt), 1);

    // Counter wrap and saturation.
    step(1'b0, 1'b1);
    repeat (255) legal_frame();
    chk("wrap_255", int'(frame_cnt), 255);
    legal_frame();
    chk("wrap_0", int'(frame_cnt), 0);
    repeat (300) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      repeat (MIN_QUIET) step(1'b0, 1'b0);
    end
    chk("sat_ecnt", int'(err_cnt), 255);
    legal_frame();
    frame_custom(PULSE_W, GAP_LEN, PULSE_W, 0);
    step(1'b0, 1'b1);                          // clr on the frame_ok edge
    chk("clr_vs_ok_strobe", int'(frame_ok), 1);
    chk("clr_vs_ok_fcnt", int'(frame_cnt), 0);
    chk("clr_vs_ok_ecnt", int'(err_cnt), 0);
    repeat (MIN_QUIET) step(1'b0, 1'b0);

    // Reset mid-frame, during the gap.
    legal_frame();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    chk("mid_reset_no_err", int'(frame_err), 0);
    @(negedge clk);
    reset = 1'b0;
    legal_frame();
    chk("post_reset_fcnt", int'(frame_cnt), 1);
    chk("post_reset_ecnt", int'(err_cnt), 0);

    // Randomized mix checked by the scoreboard.
    rand_clr_en = 1'b1;
    repeat (700) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        legal_frame();
      end else if (r <= 5) begin
        repeat ($urandom_range(1, 8)) step($urandom_range(0, 2) == 0, pick_clr());
      end else if (r <= 7) begin
        frame_custom($urandom_range(1, 2), $urandom_range(1, 3),
                     $urandom_range(1, 2), $urandom_range(0, 8));
      end else if (r == 8) begin
        step(1'b0, 1'b1);
      end else begin
        repeat ($urandom_range(1, 7)) step(1'b0, 1'b0);
      end
    end
    rand_clr_en = 1'b0;
    repeat (MIN_QUIET + 2) step(1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shutter_monitor.md
Name: shutter_monitor

Overview:
- Receive-side checker for the camera shutter line driven by the camera sequencer.
- Samples `shutter` every clock and decodes the two-pulse exposure pattern: pulse, fixed low gap, pulse, then a mandatory quiet period.
- Emits a per-frame good/error strobe, an error code, and frame/error counters for the processing stage and the testbench scoreboard.
- Sits in the same clock domain as the sequencer; `shutter` is already synchronous.

Parameters:
- PULSE_W, 1, required high width of each shutter pulse, in cycles (1..15).
- GAP_LEN, 2, required low cycles between the two pulses (1..15).
- MIN_QUIET, 6, minimum low cycles after the second pulse before a new frame may start (2..15).
- CNT_W, 8, width of frame_cnt and err_cnt.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- shutter  input  1  shutter line from the sequencer.
- clr_cnt  input  1  synchronous clear of frame_cnt and err_cnt.
- frame_ok  output  1  one-cycle pulse: a complete, legal frame was decoded.
- frame_err  output  1  one-cycle pulse: a protocol violation was detected.
- err_code  output  2  code of the last error, held until the next error: 00 QUIET, 01 WIDTH, 10 GAP_SHORT, 11 GAP_TIMEOUT.
- frame_cnt  output  CNT_W  count of good frames; wraps.
- err_cnt  output  CNT_W  count of errors; saturates at all-ones.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE, internal 4-bit counter c=0. All outputs 0, err_code=00. Asserting reset mid-frame abandons the frame silently: no error, counters cleared.
- Every output is registered. A decision made on the sample at edge N is visible after edge N, so there is 1 cycle of latency from the sampled shutter cycle.
- State machine. Each clause below is "shutter value: action, next state".
- IDLE:
  - 1: c=1, go P1.
  - 0: stay.
- P1:
  - 1 and c==PULSE_W: WIDTH error, go RECOVER (c=0).
  - 1 otherwise: c+1.
  - 0: c=1, go GAP.
- GAP:
  - 0 and c==GAP_LEN: GAP_TIMEOUT error, go RECOVER (c=1).
  - 0 otherwise: c+1.
  - 1 and c==GAP_LEN: c=1, go P2.
  - 1 and c<GAP_LEN: GAP_SHORT error, go RECOVER (c=0).
- P2:
  - 1 and c==PULSE_W: WIDTH error, go RECOVER (c=0).
  - 1 otherwise: c+1.
  - 0: frame_ok=1, frame_cnt+1, c=1, go QUIET.
- QUIET:
  - 0 and c+1==MIN_QUIET: go IDLE.
  - 0 otherwise: c+1.
  - 1: QUIET error, go RECOVER (c=0).
- RECOVER:
  - 0: c+1; when c+1==MIN_QUIET, go IDLE.
  - 1: c=0.
  - No further errors are reported while in RECOVER.
- The low cycle that ends P2 counts as quiet cycle 1. IDLE is reached after exactly MIN_QUIET consecutive lows.
- On any error:
  - frame_err=1 for one cycle.
  - err_code is updated in the same edge.
  - err_cnt+1, unless err_cnt is all-ones.
- frame_ok and frame_err are never high in the same cycle.
- clr_cnt:
  - Clears both counters on the next edge.
  - If clr_cnt coincides with frame_ok or frame_err, clr wins: the counter reads 0.
  - The strobes and err_code are unaffected.
- frame_cnt wraps from all-ones to 0.
- Illegal state encodings: go to RECOVER with c=0; no error pulse.
- The counter is 4 bits and never exceeds 15, given the parameter ranges.

Test Plan (default parameters):
- Legal frame: shutter 1,0,0,1,0 then 8 zeros -> frame_ok high exactly 1 cycle, on the edge after the 5th sample. frame_cnt=1, err_cnt=0, busy drops after the 6th consecutive low.
- Wide pulse: shutter 1,1 -> frame_err after the 2nd sample, err_code=01. Then 6 lows return to IDLE, and a following legal frame gives frame_ok, frame_cnt=1.
- Short gap and timeout: 1,0,1 -> err_code=10. After recovery, 1,0,0,0 -> err_code=11 on the 4th sample. err_cnt=2.
- Quiet violation: legal frame, then shutter=1 on quiet cycle 3 -> frame_err with err_code=00, frame_cnt=1, err_cnt=1. The pulse is not decoded as a new frame.
- Counter wrap and saturation: 256 legal frames -> frame_cnt wraps to 0. 300 errors -> err_cnt stays at 255. clr_cnt coincident with frame_ok -> frame_cnt=0.
- Reset mid-frame: assert reset during GAP -> all outputs 0 immediately, no frame_err. The next legal frame decodes normally.
